adc_capture_sequencer: RTL and testbench
========================================

Name: adc_capture_sequencer

Overview:
Sequences multi-burst acquisitions on the CMOS ADC capture block by driving its Work level and consuming its Done/Last handshake. Runs a programmed number of bursts with a programmable idle gap between bursts. Gates each burst on downstream stream readiness and supervises each burst with a watchdog. Sits between the PS-side control registers and the ADC capture path, in the i_CMOS_Clk domain.

Parameters:
CNT_W, 16, width of the burst-count, burst-index and gap counters
TIMEOUT_CYCLES, 200000, maximum cycles from Work assertion to Done before a timeout error
TMO_W, 18, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT_CYCLES

Ports:
i_CMOS_Clk  in  1  ADC sample clock; the only clock
i_Rst_n  in  1  synchronous active-low reset
i_Start  in  1  single-cycle start request; sampled only in IDLE
i_Abort  in  1  level; stops the sequence at the next cycle
i_Burst_Count  in  CNT_W  number of bursts; latched on accepted start
i_Gap_Cycles  in  CNT_W  idle cycles between bursts; latched on accepted start
i_Stream_Ready  in  1  downstream (stream master/DMA) can accept a full burst
i_ADC_Done  in  1  capture block Done level
i_ADC_Last  in  1  capture block last-sample strobe
o_ADC_Work  out  1  level to capture block Work input
o_Busy  out  1  high in every state except IDLE
o_Burst_Idx  out  CNT_W  index of the current or last burst, 0-based
o_Seq_Done  out  1  one-cycle pulse on completion, abort or error
o_Timeout  out  1  sticky; cleared on the next accepted start
o_Aborted  out  1  sticky; cleared on the next accepted start
o_Last_Seen  out  1  sticky per burst; set by i_ADC_Last, cleared on Work rise

Behaviour:
- Reset, synchronous and applied whenever i_Rst_n is 0: state=IDLE. All outputs are 0 and all counters are 0. Reset mid-burst drops o_ADC_Work in the same edge.
- All outputs are registered.
- IDLE:
  - i_Start=1 latches Burst_Count and Gap_Cycles, clears o_Timeout and o_Aborted, and sets o_Burst_Idx=0.
  - If the latched count is 0, go to FINISH; no Work pulse is issued.
  - Otherwise go to WAIT_RDY.
- WAIT_RDY: when i_Stream_Ready=1 and i_ADC_Done=0, go to RUN; o_ADC_Work rises on that edge. Latency from i_Start to o_ADC_Work=1 is 2 cycles when ready is already high.
- RUN:
  - o_ADC_Work is held at 1 and the watchdog increments each cycle.
  - i_ADC_Last=1 sets o_Last_Seen.
  - i_ADC_Done=1 drops Work and goes to RELEASE.
  - Watchdog reaching TIMEOUT_CYCLES-1 with Done still 0 sets o_Timeout, drops Work and goes to DRAIN.
- RELEASE: wait for i_ADC_Done=0, which the capture block produces once Work is low.
  - If this was the last burst (Burst_Idx==Count-1), go to FINISH.
  - Otherwise increment o_Burst_Idx, load the gap counter and go to GAP.
- GAP: count down i_Gap_Cycles cycles, then go to WAIT_RDY. A gap of 0 goes to WAIT_RDY on the next cycle.
- DRAIN: Work=0. Wait for i_ADC_Done=0, then go to FINISH. DRAIN is also the abort path.
- FINISH: pulse o_Seq_Done for one cycle, then go to IDLE.
- Abort:
  - i_Abort=1 in WAIT_RDY, RUN, RELEASE or GAP sets o_Aborted, forces Work=0 and goes to DRAIN.
  - Abort has priority over Done and timeout in the same cycle.
  - Abort is ignored in IDLE, DRAIN and FINISH.
- i_Start outside IDLE is ignored; it is not queued.
- If Done and the watchdog expiry coincide in RUN, Done wins and o_Timeout is not set.
- o_Burst_Idx never exceeds Count-1. Counters do not wrap.

Decomposition:
- Shared package adc_seq_pkg holds the state enum (IDLE, WAIT_RDY, RUN, RELEASE, GAP, DRAIN, FINISH) and the default CNT_W/TIMEOUT_CYCLES constants.
- One sub-module, adc_seq_watchdog: a loadable up-counter with clear and expiry flag, reused later for the SPI config sequencer.

Test Plan:
- Count=3, Gap=10, ready=1, model Done after 100000 Work cycles -> exactly 3 Work pulses; gaps of 10 cycles plus the handshake; o_Burst_Idx steps 0,1,2; a single o_Seq_Done; o_Timeout=0.
- Count=0, start -> o_Seq_Done 2 cycles later; o_ADC_Work never rises.
- Count=2, ready held low for 500 cycles, then high -> Work rises 1 cycle after ready goes high; o_Busy=1 throughout.
- TIMEOUT_CYCLES=64, model never raises Done -> Work drops after 64 cycles of Work; o_Timeout=1; model Done stays 0, so DRAIN exits at once; o_Seq_Done pulses.
- Abort asserted in burst 1 of 4, mid-RUN -> Work=0 next edge; o_Aborted=1; o_Burst_Idx=1; one o_Seq_Done; a new start clears o_Aborted.
- Reset pulled low during RUN -> Work=0 and all outputs 0 on that edge; i_Start during GAP has no effect.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and default sizing for the ADC capture sequencer.
package adc_seq_pkg;
  localparam int CNT_W_DEF          = 16;
  localparam int TIMEOUT_CYCLES_DEF = 200000;
  localparam int TMO_W_DEF          = 18;

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, RUN, RELEASE, GAP, DRAIN, FINISH
  } seq_state_e;
endpackage

// File: rtl/adc_seq_watchdog.sv
// Loadable saturating up-counter with clear; expired is high once the count
// sits at LIMIT-1.
module adc_seq_watchdog
  import adc_seq_pkg::*;
#(
  parameter int W     = TMO_W_DEF,
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr)                count <= '0;
    else if (load)                    count <= load_val;
    else if (en && (count != LAST))   count <= count + W'(1);
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/adc_capture_sequencer.sv
// Multi-burst sequencer for the CMOS ADC capture block: drives Work, consumes
// Done/Last, inserts inter-burst gaps and supervises each burst with a watchdog.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TMO_W          = TMO_W_DEF
) (
  input  logic             i_CMOS_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Start,
  input  logic             i_Abort,
  input  logic [CNT_W-1:0] i_Burst_Count,
  input  logic [CNT_W-1:0] i_Gap_Cycles,
  input  logic             i_Stream_Ready,
  input  logic             i_ADC_Done,
  input  logic             i_ADC_Last,
  output logic             o_ADC_Work,
  output logic             o_Busy,
  output logic [CNT_W-1:0] o_Burst_Idx,
  output logic             o_Seq_Done,
  output logic             o_Timeout,
  output logic             o_Aborted,
  output logic             o_Last_Seen
);
  seq_state_e       state;
  logic [CNT_W-1:0] cnt_lat, gap_lat, gap_cnt;
  logic             tmo_expired, abortable;

  // Watchdog is held at zero outside RUN, so it restarts on every Work rise.
  adc_seq_watchdog #(.W(TMO_W), .LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk      (i_CMOS_Clk),
    .rst_n    (i_Rst_n),
    .clr      (state != RUN),
    .en       (state == RUN),
    .load     (1'b0),
    .load_val ('0),
    .expired  (tmo_expired)
  );

  assign abortable = (state == WAIT_RDY) || (state == RUN) ||
                     (state == RELEASE)  || (state == GAP);

  always_ff @(posedge i_CMOS_Clk) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      cnt_lat     <= '0;
      gap_lat     <= '0;
      gap_cnt     <= '0;
      o_ADC_Work  <= 1'b0;
      o_Busy      <= 1'b0;
      o_Burst_Idx <= '0;
      o_Seq_Done  <= 1'b0;
      o_Timeout   <= 1'b0;
      o_Aborted   <= 1'b0;
      o_Last_Seen <= 1'b0;
    end else begin
      o_Seq_Done <= 1'b0;
      if (abortable && i_Abort) begin
        o_Aborted  <= 1'b1;
        o_ADC_Work <= 1'b0;
        state      <= DRAIN;
      end else begin
        case (state)
          IDLE: if (i_Start) begin
            cnt_lat     <= i_Burst_Count;
            gap_lat     <= i_Gap_Cycles;
            o_Timeout   <= 1'b0;
            o_Aborted   <= 1'b0;
            o_Burst_Idx <= '0;
            o_Busy      <= 1'b1;
            state       <= (i_Burst_Count == '0) ? FINISH : WAIT_RDY;
          end
          WAIT_RDY: if (i_Stream_Ready && !i_ADC_Done) begin
            o_ADC_Work  <= 1'b1;
            o_Last_Seen <= 1'b0;
            state       <= RUN;
          end
          RUN: begin
            if (i_ADC_Last) o_Last_Seen <= 1'b1;
            // Done outranks a coinciding watchdog expiry.
            if (i_ADC_Done) begin
              o_ADC_Work <= 1'b0;
              state      <= RELEASE;
            end else if (tmo_expired) begin
              o_Timeout  <= 1'b1;
              o_ADC_Work <= 1'b0;
              state      <= DRAIN;
            end
          end
          RELEASE: if (!i_ADC_Done) begin
            if (o_Burst_Idx == cnt_lat - CNT_W'(1)) begin
              state <= FINISH;
            end else begin
              o_Burst_Idx <= o_Burst_Idx + CNT_W'(1);
              gap_cnt     <= gap_lat;
              state       <= GAP;
            end
          end
          GAP: begin
            if (gap_cnt == '0) state <= WAIT_RDY;
            else               gap_cnt <= gap_cnt - CNT_W'(1);
          end
          DRAIN: if (!i_ADC_Done) state <= FINISH;
          FINISH: begin
            o_Seq_Done <= 1'b1;
            o_Busy     <= 1'b0;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Table-driven cycle vectors plus directed multi-cycle sequences against a
// small capture-block model.
module tb_adc_capture_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b0;
  logic [15:0] cnt = '0, gap = '0;
  logic        t_done = 1'b0, t_last = 1'b0, m_done = 1'b0, m_last = 1'b0;
  logic        model_on = 1'b0;
  logic        adc_done, adc_last;
  logic        work, busy, seq_done, tmo, abrt, lseen;
  logic [15:0] idx;
  int          done_after = 0, wcnt = 0;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign adc_done = model_on ? m_done : t_done;
  assign adc_last = model_on ? m_last : t_last;

  adc_capture_sequencer #(.CNT_W(16), .TIMEOUT_CYCLES(64), .TMO_W(7)) dut (
    .i_CMOS_Clk     (clk),
    .i_Rst_n        (rst_n),
    .i_Start        (start),
    .i_Abort        (abort),
    .i_Burst_Count  (cnt),
    .i_Gap_Cycles   (gap),
    .i_Stream_Ready (ready),
    .i_ADC_Done     (adc_done),
    .i_ADC_Last     (adc_last),
    .o_ADC_Work     (work),
    .o_Busy         (busy),
    .o_Burst_Idx    (idx),
    .o_Seq_Done     (seq_done),
    .o_Timeout      (tmo),
    .o_Aborted      (abrt),
    .o_Last_Seen    (lseen)
  );

  // Capture block: Done after done_after Work cycles (0 = never), Last one
  // cycle earlier, Done released once Work is seen low.
  always @(negedge clk) begin
    if (work) begin
      wcnt   = wcnt + 1;
      m_done = (done_after != 0) && (wcnt >= done_after);
      m_last = (done_after != 0) && (wcnt == done_after - 1);
    end else begin
      wcnt   = 0;
      m_done = 1'b0;
      m_last = 1'b0;
    end
  end

  typedef struct packed {
    logic rst_n, start, abort;
    logic [15:0] cnt, gap;
    logic ready, done, last;
  } in_t;
  typedef struct packed {
    logic work, busy;
    logic [15:0] idx;
    logic sdone, tmo, abrt, lseen;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  vec_t tbl[40];
  int   nv = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, s, a, input int c, g, input logic rd, d, l,
                     input logic w, b, input int ix, input logic sd, tm, ab, ls);
    tbl[nv].i = {r, s, a, 16'(c), 16'(g), rd, d, l};
    tbl[nv].o = {w, b, 16'(ix), sd, tm, ab, ls};
    nv++;
  endtask

  initial begin
    out_t act;
    int rises, sd, hi, lo, bad_hi, bad_lo, bad_idx, bad;
    logic prevw, seen;

    //   rst st ab cnt gap rdy dn ls   work busy idx sd tmo ab ls
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);  // reset
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);  // count 0 -> FINISH
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 2, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);  // count 2, gap 1
    add(1, 0, 0, 2, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0, 0);  // stale Done blocks
    add(1, 0, 0, 2, 1, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 2, 1, 1, 0, 1,   1, 1, 0, 0, 0, 0, 1);  // Last seen
    add(1, 0, 0, 2, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 2, 1, 1, 1, 0,   0, 1, 0, 0, 0, 0, 1);
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 1);  // -> GAP
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 1);
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 1);  // -> WAIT_RDY
    add(1, 0, 0, 2, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0);  // Work rise clears Last
    add(1, 1, 0, 0, 1, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0);  // start ignored
    add(1, 0, 0, 2, 1, 1, 1, 0,   0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);  // last burst -> FINISH
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 2, 1, 1, 0, 0,   0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 4, 0, 1, 0, 0,   0, 1, 0, 0, 0, 0, 0);  // count 4, gap 0
    add(1, 0, 0, 4, 0, 1, 0, 0,   1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 0, 1, 1, 0,   0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 4, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 4, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 0, 4, 0, 1, 0, 0,   1, 1, 1, 0, 0, 0, 0);  // burst 1 RUN
    add(1, 0, 1, 4, 0, 1, 1, 0,   0, 1, 1, 0, 0, 1, 0);  // abort beats Done
    add(1, 0, 1, 4, 0, 1, 1, 0,   0, 1, 1, 0, 0, 1, 0);  // DRAIN holds on Done
    add(1, 0, 0, 4, 0, 1, 0, 0,   0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 0, 4, 0, 1, 0, 0,   0, 0, 1, 1, 0, 1, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);  // start clears Aborted
    add(1, 0, 1, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);  // abort in WAIT_RDY
    add(1, 0, 0, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0);  // abort ignored in IDLE

    for (int k = 0; k < nv; k++) begin
      {rst_n, start, abort, cnt, gap, ready, t_done, t_last} = tbl[k].i;
      tick;
      act = {work, busy, idx, seq_done, tmo, abrt, lseen};
      chk($sformatf("vec%0d", k), 32'(act), 32'(tbl[k].o));
    end
    abort = 0; t_done = 0; t_last = 0; model_on = 1;

    // Three bursts, gap 10, Done after 20 Work cycles.
    cnt = 3; gap = 10; ready = 1; done_after = 20; start = 1; tick; start = 0;
    rises = 0; sd = 0; hi = 0; lo = 0; bad_hi = 0; bad_lo = 0; bad_idx = 0; prevw = 0;
    for (int c = 0; c < 3000 && sd == 0; c++) begin
      tick;
      if (work && !prevw) begin
        if (idx !== 16'(rises)) bad_idx++;
        if (rises > 0 && lo != 13) bad_lo++;
        rises++; hi = 0;
      end
      if (!work && prevw) begin
        if (hi != 20) bad_hi++;
        lo = 0;
      end
      if (work) hi++; else lo++;
      if (seq_done) sd++;
      prevw = work;
    end
    for (int c = 0; c < 5; c++) begin tick; if (seq_done) sd++; end
    chk("multi_rises", 32'(rises), 3);
    chk("multi_seq_done", 32'(sd), 1);
    chk("multi_idx_steps", 32'(bad_idx), 0);
    chk("multi_gap_len", 32'(bad_lo), 0);
    chk("multi_work_len", 32'(bad_hi), 0);
    chk("multi_timeout", 32'(tmo), 0);
    chk("multi_last_seen", 32'(lseen), 1);
    chk("multi_final_idx", 32'(idx), 2);
    chk("multi_busy", 32'(busy), 0);

    // Ready held low for 500 cycles.
    cnt = 2; gap = 0; ready = 0; done_after = 5; start = 1; tick; start = 0;
    bad = 0;
    for (int c = 0; c < 500; c++) begin
      tick;
      if (work !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("rdy_hold", 32'(bad), 0);
    ready = 1; tick;
    chk("rdy_work_rise", 32'(work), 1);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin tick; seen = seq_done; end
    chk("rdy_seq_done", 32'(seen), 1);

    // Watchdog: Done never arrives.
    cnt = 1; done_after = 0; ready = 1; start = 1; tick; start = 0;
    for (int c = 0; c < 10 && !work; c++) tick;
    hi = 0;
    for (int c = 0; c < 200 && work; c++) begin hi++; tick; end
    chk("tmo_work_len", 32'(hi), 64);
    chk("tmo_flag", 32'(tmo), 1);
    tick;
    chk("tmo_finish_no_pulse", 32'(seq_done), 0);
    tick;
    chk("tmo_seq_done", 32'(seq_done), 1);
    tick;
    chk("tmo_sticky_idle", 32'({tmo, busy}), 32'b10);

    // Start during GAP is ignored; reset mid-RUN clears everything.
    cnt = 2; gap = 5; done_after = 10; start = 1; tick; start = 0;
    chk("start_clears_tmo", 32'(tmo), 0);
    for (int c = 0; c < 100 && idx != 16'd1; c++) tick;
    cnt = 0; start = 1; tick; start = 0;
    chk("gap_start_ignored", 32'({busy, idx, seq_done}), 32'({1'b1, 16'd1, 1'b0}));
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin tick; seen = work; end
    chk("gap_second_burst", 32'({seen, idx}), 32'({1'b1, 16'd1}));
    tick; tick;
    rst_n = 0; tick;
    chk("rst_mid_run", 32'({work, busy, idx, seq_done, tmo, abrt, lseen}), 0);
    rst_n = 1; tick; tick; tick;
    chk("rst_stays_idle", 32'({work, busy, seq_done}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
